joystick_tx: RTL and testbench
==============================

Name: joystick_tx

Overview:
- Transmit side of the joystick serial link: snapshots an 11-bit X axis, an 11-bit Y axis and a button bit.
- Frames them into a 7-byte packet: sync 0xAA, sync 0xAA, X low, X high, Y low, Y high, Z.
- Serialises the packet as 8N1 UART on Tx at CLKS_PER_BIT clocks per bit, directly consumable by the joystick receiver/driver.
- Sits at the top IO level on the board or emulator side; all logic runs in the clk50 domain.

Parameters:
- CLKS_PER_BIT, 5208: clk50 cycles per UART bit (9600 baud at 50 MHz); legal range >= 2.
- SYNCPATTERN, 8'hAA: value of both sync bytes.
- PERIOD_CLKS, 500000: auto-send interval in clk50 cycles; used only with JOYTX_AUTOSEND_EN; must be >= 70*CLKS_PER_BIT+1.

Ports:
- clk50  input  1  system clock, 50 MHz
- nreset  input  1  asynchronous, active-low reset
- xA  input  11  X axis value to send
- yA  input  11  Y axis value to send
- zBt  input  1  button state to send
- send  input  1  level/pulse request to transmit one packet
- Tx  output  1  UART serial out, idle high
- busy  output  1  high while a packet is in flight
- done  output  1  one-cycle pulse when a packet's last stop bit completes

Behaviour:
- Reset (async, nreset low): Tx=1, busy=0, done=0, FSM=IDLE, byte index=0, bit counter=0, baud counter=0, period counter=0. Asserting reset mid-packet aborts at once; Tx returns high with no partial bits afterwards.
- Packet byte order and contents:
  - B0 = SYNCPATTERN
  - B1 = SYNCPATTERN
  - B2 = x[7:0]
  - B3 = {5'b0, x[10:8]}
  - B4 = y[7:0]
  - B5 = {5'b0, y[10:8]}
  - B6 = {7'b0, z}
- Snapshot: xA/yA/zBt are registered in the cycle a request is accepted. Later input changes do not affect the packet in flight.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1, busy=0. On request: capture the snapshot, set byte index=0, go to START, set busy=1 in the next cycle.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx=current byte bit[index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles.
    - If byte index < 6: increment the index and go to START. No inter-byte idle gap.
    - If byte index = 6: go to IDLE and pulse done for exactly 1 cycle (the first IDLE cycle). busy=0 in that same cycle.
- Latency: first Tx falling edge appears 1 cycle after the accepting cycle. A packet occupies exactly 70*CLKS_PER_BIT cycles of busy=1.
- Request acceptance:
  - A request is only accepted in IDLE. send while busy=1 is ignored, not queued.
  - send held high gives back-to-back packets. Re-acceptance occurs in the done cycle, so packets are separated by exactly 1 idle cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is cleared on every state change.
- Tx is driven from a register (glitch-free).

Optional Feature:
- JOYTX_AUTOSEND_EN defined:
  - A free-running period counter (0..PERIOD_CLKS-1) issues an internal request at each wrap.
  - The effective request is send OR the internal tick.
  - A tick arriving while busy is dropped; the counter keeps running and is not re-phased.
- JOYTX_AUTOSEND_EN not defined: no period counter is built; packets are sent only on send.

Test Plan (CLKS_PER_BIT=4, PERIOD_CLKS=300):
- Reset check: hold nreset low, then release -> Tx=1, busy=0, done=0; Tx stays high for 100 cycles with send=0.
- Framing: x=11'h5A3, y=11'h0F1, z=1, pulse send 1 cycle -> decoded bytes AA AA A3 05 F1 00 01; each bit 4 cycles; busy high for 280 cycles; done single pulse at the end.
- Snapshot: start with x=11'h7FF, change x to 0 mid-packet -> B2=FF, B3=07 on the wire.
- Ignored request: pulse send while busy during B3 -> only one packet transmitted, then Tx idle.
- Back-to-back / abort: send held high -> second start bit begins 1 cycle after done. Drop nreset during B4 -> Tx=1 immediately, busy=0, and a new send then produces a complete packet.
- JOYTX_AUTOSEND_EN: send=0 -> packets start every 300 cycles, each with correct contents.

Source files
------------

// File: rtl/joystick_tx_if.sv
// joystick_tx_if: request/status bundle between the joystick source and its UART framer.
// Master supplies axis/button values and send; slave reports Tx, busy and done.
interface joystick_tx_if;
  logic [10:0] xA;
  logic [10:0] yA;
  logic zBt;
  logic send;
  logic Tx;
  logic busy;
  logic done;
  modport master(output xA, yA, zBt, send, input Tx, busy, done);
  modport slave(input xA, yA, zBt, send, output Tx, busy, done);
endinterface

// File: rtl/joystick_tx.sv
// joystick_tx: snapshots X/Y/button and sends a 7-byte sync-prefixed packet as 8N1 UART on Tx.
// Define JOYTX_AUTOSEND_EN to also request a packet every PERIOD_CLKS cycles.
module joystick_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter logic [7:0] SYNCPATTERN = 8'hAA,
  parameter int PERIOD_CLKS = 500000
) (
  input logic clk50,
  input logic nreset,
  joystick_tx_if.slave jif
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, stateNext;
  logic [BAUD_W-1:0] baudCnt, baudNext;
  logic [2:0] bitIdx, bitNext, byteIdx, byteNext;
  logic [10:0] xSnap, ySnap;
  logic zSnap;
  logic req, accept, baudLast, txNext, doneNext, txReg, doneReg;
  logic [7:0] curByte;
`ifdef JOYTX_AUTOSEND_EN
  localparam int PER_W = $clog2(PERIOD_CLKS);
  logic [PER_W-1:0] periodCnt;
  logic tick;
  assign tick = periodCnt == PER_W'(PERIOD_CLKS - 1);
  // Free-running: a tick landing while busy is simply lost, phase is never adjusted.
  always_ff @(posedge clk50 or negedge nreset)
    if (!nreset) periodCnt <= '0;
    else periodCnt <= tick ? '0 : periodCnt + 1'b1;
  assign req = jif.send | tick;
`else
  assign req = jif.send;
`endif
  assign accept = state == IDLE && req;
  assign baudLast = baudCnt == BAUD_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk50 or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = req ? START : IDLE;
      START: stateNext = baudLast ? DATA : START;
      DATA: stateNext = (baudLast && bitIdx == 3'd7) ? STOP : DATA;
      default: stateNext = baudLast ? (byteIdx == 3'd6 ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    baudNext = (stateNext != state || baudLast) ? '0 : baudCnt + 1'b1;
    bitNext = state != DATA ? 3'd0 : baudLast ? bitIdx + 3'd1 : bitIdx;
    byteNext = accept ? 3'd0 : (state == STOP && stateNext == START) ? byteIdx + 3'd1 : byteIdx;
  end
  // Tx is computed from next-cycle state so the register output matches the FSM with no lag.
  always_comb begin
    curByte = byteNext <= 3'd1 ? SYNCPATTERN :
              byteNext == 3'd2 ? xSnap[7:0] :
              byteNext == 3'd3 ? {5'b0, xSnap[10:8]} :
              byteNext == 3'd4 ? ySnap[7:0] :
              byteNext == 3'd5 ? {5'b0, ySnap[10:8]} : {7'b0, zSnap};
    txNext = stateNext == START ? 1'b0 : stateNext == DATA ? curByte[bitNext] : 1'b1;
    doneNext = state == STOP && stateNext == IDLE;
  end
  always_ff @(posedge clk50 or negedge nreset)
    if (!nreset) begin
      baudCnt <= '0;
      bitIdx <= 3'd0;
      byteIdx <= 3'd0;
      xSnap <= '0;
      ySnap <= '0;
      zSnap <= 1'b0;
      txReg <= 1'b1;
      doneReg <= 1'b0;
    end else begin
      baudCnt <= baudNext;
      bitIdx <= bitNext;
      byteIdx <= byteNext;
      txReg <= txNext;
      doneReg <= doneNext;
      if (accept) begin
        xSnap <= jif.xA;
        ySnap <= jif.yA;
        zSnap <= jif.zBt;
      end
    end
  assign jif.Tx = txReg;
  assign jif.done = doneReg;
  assign jif.busy = state != IDLE;
endmodule

// File: tb/tb_joystick_tx.sv
// tb_joystick_tx: directed checks of packet framing, snapshot, ignored/back-to-back requests and reset abort.
module tb_joystick_tx;
  localparam int CPB = 4;
  localparam int PER = 300;
  logic clk50 = 1'b0;
  logic nreset = 1'b0;
  int errors = 0;
  int checks = 0;
  int busyCnt = 0;
  int doneCnt = 0;
  logic [7:0] rx [7];
  joystick_tx_if jif();
  joystick_tx #(.CLKS_PER_BIT(CPB), .SYNCPATTERN(8'hAA), .PERIOD_CLKS(PER)) dut (
    .clk50(clk50), .nreset(nreset), .jif(jif));
  always #5 clk50 = ~clk50;
  always @(posedge clk50) begin
    busyCnt <= busyCnt + int'(jif.busy);
    doneCnt <= doneCnt + int'(jif.done);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic waitStart(input string tag, input int limit, output int n);
    n = 0;
    while (jif.Tx !== 1'b0 && n < limit) begin
      @(negedge clk50);
      n++;
    end
    chk($sformatf("%s_start", tag), 32'(jif.Tx === 1'b0), 32'd1);
  endtask
  task automatic recvByte(input string tag, output logic [7:0] b);
    logic [9:0] f;
    int bad;
    bad = 0;
    f = '0;
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk50);
        if (c == 0) f[i] = jif.Tx;
        else if (jif.Tx !== f[i]) bad++;
      end
    b = f[8:1];
    chk($sformatf("%s_hold", tag), bad, 0);
    chk($sformatf("%s_startstop", tag), {f[9], f[0]}, 2'b10);
  endtask
  task automatic recvPacket(input string tag, input logic [55:0] exp);
    int n;
    waitStart(tag, 400, n);
    for (int j = 0; j < 7; j++) begin
      if (j != 0) @(negedge clk50);
      recvByte($sformatf("%s_b%0d", tag, j), rx[j]);
    end
    for (int j = 0; j < 7; j++) chk($sformatf("%s_byte%0d", tag, j), rx[j], exp[55-8*j -: 8]);
  endtask
  task automatic setIn(input logic [10:0] x, input logic [10:0] y, input logic z);
    jif.xA = x;
    jif.yA = y;
    jif.zBt = z;
  endtask
  task automatic idleCheck(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk50);
      if (jif.Tx !== 1'b1 || jif.busy !== 1'b0) bad++;
    end
    chk(tag, bad, 0);
  endtask
  initial begin
    int n, b0, d0;
    jif.send = 1'b0;
    setIn(11'h000, 11'h000, 1'b0);
    repeat (3) @(negedge clk50);
    chk("rst_tx", jif.Tx, 1);
    chk("rst_busy", jif.busy, 0);
    nreset = 1'b1;
    @(negedge clk50);
    chk("post_rst_tx", jif.Tx, 1);
    chk("post_rst_busy", jif.busy, 0);
    chk("post_rst_done", jif.done, 0);
    idleCheck("rst_idle100", 99);
`ifdef JOYTX_AUTOSEND_EN
    setIn(11'h2C5, 11'h5E6, 1'b1);
    waitStart("auto1", 400, n);
    chk("auto_phase", n, 200);
    recvPacket("auto1", 56'hAAAA_C502_E605_01);
    @(negedge clk50);
    waitStart("auto2", 400, n);
    chk("auto_interval", n, 20);
    recvPacket("auto2", 56'hAAAA_C502_E605_01);
`else
    setIn(11'h5A3, 11'h0F1, 1'b1);
    b0 = busyCnt;
    d0 = doneCnt;
    @(negedge clk50);
    jif.send = 1'b1;
    @(negedge clk50);
    jif.send = 1'b0;
    chk("latency_tx", jif.Tx, 0);
    chk("latency_busy", jif.busy, 1);
    recvPacket("frame", 56'hAAAA_A305_F100_01);
    @(negedge clk50);
    chk("frame_done", jif.done, 1);
    chk("frame_busy_end", jif.busy, 0);
    @(negedge clk50);
    chk("frame_done_1cyc", jif.done, 0);
    chk("frame_busy_cycles", busyCnt - b0, 280);
    chk("frame_done_count", doneCnt - d0, 1);
    setIn(11'h7FF, 11'h123, 1'b0);
    @(negedge clk50);
    jif.send = 1'b1;
    @(negedge clk50);
    jif.send = 1'b0;
    setIn(11'h000, 11'h000, 1'b1);
    recvPacket("snap", 56'hAAAA_FF07_2301_00);
    repeat (3) @(negedge clk50);
    setIn(11'h400, 11'h7FF, 1'b1);
    d0 = doneCnt;
    jif.send = 1'b1;
    @(negedge clk50);
    jif.send = 1'b0;
    fork
      recvPacket("ign", 56'hAAAA_0004_FF07_01);
      begin
        repeat (130) @(negedge clk50);
        jif.send = 1'b1;
        @(negedge clk50);
        jif.send = 1'b0;
      end
    join
    @(negedge clk50);
    chk("ign_done", jif.done, 1);
    idleCheck("ign_no_second", 60);
    chk("ign_done_count", doneCnt - d0, 1);
    setIn(11'h0AB, 11'h3CD, 1'b0);
    jif.send = 1'b1;
    recvPacket("b2b", 56'hAAAA_AB00_CD03_00);
    @(negedge clk50);
    chk("b2b_done", jif.done, 1);
    chk("b2b_gap_tx", jif.Tx, 1);
    chk("b2b_gap_busy", jif.busy, 0);
    @(negedge clk50);
    chk("b2b_restart_tx", jif.Tx, 0);
    chk("b2b_restart_busy", jif.busy, 1);
    jif.send = 1'b0;
    repeat (165) @(negedge clk50);
    nreset = 1'b0;
    #1;
    chk("abort_tx", jif.Tx, 1);
    chk("abort_busy", jif.busy, 0);
    chk("abort_done", jif.done, 0);
    repeat (2) @(negedge clk50);
    nreset = 1'b1;
    idleCheck("abort_idle", 50);
    setIn(11'h1FF, 11'h200, 1'b1);
    jif.send = 1'b1;
    @(negedge clk50);
    jif.send = 1'b0;
    recvPacket("after_abort", 56'hAAAA_FF01_0002_01);
    @(negedge clk50);
    chk("after_abort_done", jif.done, 1);
`endif
    repeat (5) @(negedge clk50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
